// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array control path.
package systolic_pkg;

    localparam int unsigned SIZE_W_DEF    = 4;
    localparam int unsigned NUM_INSTR_DEF = 8;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LATCH,
        CLEAR,
        FEED,
        SETTLE,
        DRAIN,
        NEXT,
        DONE
    } seq_state_t;

    // Cycles the skewed wavefront needs to finish propagating through an NxN array.
    function automatic int unsigned settle_len(input int unsigned n);
        return (n == 0) ? 0 : (2 * n) - 2;
    endfunction

endpackage

// File: rtl/systolic_sequencer_phase_counter.sv
// Shared phase counter: counts remaining cycles down and the phase index up.
module phase_counter #(
    parameter int unsigned CW = 5,
    parameter int unsigned IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [IW-1:0] idx,
    output logic          last
);

    logic [CW-1:0] rem;

    // Load restarts the phase; each enabled cycle consumes one step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            idx <= '0;
        end else if (load) begin
            rem <= load_val;
            idx <= '0;
        end else if (dec) begin
            rem <= rem - CW'(1);
            idx <= idx + IW'(1);
        end
    end

    assign last = (rem == CW'(1));

endmodule

// File: rtl/systolic_sequencer.sv
// Job sequencer: fetches matrix sizes and walks the array through
// clear, feed, settle and drain for each job.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int unsigned SIZE_W    = SIZE_W_DEF,
    parameter int unsigned NUM_INSTR = NUM_INSTR_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic                      imem_read,
    input  logic [SIZE_W-1:0]         imem_value,
    output logic                      acc_clear,
    output logic                      feed_en,
    output logic [SIZE_W-1:0]         feed_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SIZE_W-1:0]         drain_idx,
    output logic [SIZE_W-1:0]         cur_n,
    output logic [$clog2(NUM_INSTR):0] job_count,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned CW = SIZE_W + 1;
    localparam int unsigned JW = $clog2(NUM_INSTR) + 1;

    seq_state_t    state;
    seq_state_t    nxt;
    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_dec;
    logic [SIZE_W-1:0] cnt_idx;
    logic          cnt_last;
    logic [JW-1:0] jc_inc;

    assign jc_inc = job_count + JW'(1);

    phase_counter #(
        .CW(CW),
        .IW(SIZE_W)
    ) u_phase (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .idx     (cnt_idx),
        .last    (cnt_last)
    );

    // Next-state decision and phase-counter reload on every phase entry.
    always_comb begin
        nxt      = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state)
            IDLE:   if (start) nxt = FETCH;
            FETCH:  nxt = LATCH;
            LATCH:  nxt = (imem_value == '0) ? DONE : CLEAR;
            CLEAR: begin
                nxt      = FEED;
                cnt_load = 1'b1;
                cnt_val  = {1'b0, cur_n};
            end
            FEED: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    cnt_load = 1'b1;
                    if (cur_n == SIZE_W'(1)) begin
                        nxt     = DRAIN;
                        cnt_val = {1'b0, cur_n};
                    end else begin
                        nxt     = SETTLE;
                        cnt_val = CW'(settle_len(32'(cur_n)));
                    end
                end
            end
            SETTLE: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    nxt      = DRAIN;
                    cnt_load = 1'b1;
                    cnt_val  = {1'b0, cur_n};
                end
            end
            DRAIN: begin
                cnt_dec = out_ready;
                if (out_ready && cnt_last) nxt = NEXT;
            end
            NEXT:    nxt = (jc_inc == JW'(NUM_INSTR)) ? DONE : FETCH;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort && state != IDLE && state != DONE) nxt = IDLE;
    end

    // State, job bookkeeping and strobes registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            imem_read <= 1'b0;
            acc_clear <= 1'b0;
            feed_en   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur_n     <= '0;
            job_count <= '0;
        end else begin
            state     <= nxt;
            imem_read <= (nxt == FETCH);
            acc_clear <= (nxt == CLEAR);
            feed_en   <= (nxt == FEED);
            out_valid <= (nxt == DRAIN);
            busy      <= (nxt != IDLE);
            done      <= (nxt == DONE);
            if (state == IDLE && start) job_count <= '0;
            if (state == LATCH) cur_n <= imem_value;
            if (state == NEXT && nxt != IDLE) job_count <= jc_inc;
        end
    end

    assign feed_idx  = (state == FEED)  ? cnt_idx : '0;
    assign drain_idx = (state == DRAIN) ? cnt_idx : '0;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer with a behavioural instruction memory.
module tb_systolic_sequencer;
    import systolic_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       imem_read;
    logic [3:0] imem_value;
    logic       acc_clear;
    logic       feed_en;
    logic [3:0] feed_idx;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] drain_idx;
    logic [3:0] cur_n;
    logic [3:0] job_count;
    logic       busy;
    logic       done;

    logic [3:0] prog [0:15];
    logic [3:0] ptr;
    logic       mem_clr;

    int checks = 0;
    int errors = 0;

    systolic_sequencer #(
        .SIZE_W(4),
        .NUM_INSTR(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .imem_read (imem_read),
        .imem_value(imem_value),
        .acc_clear (acc_clear),
        .feed_en   (feed_en),
        .feed_idx  (feed_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drain_idx (drain_idx),
        .cur_n     (cur_n),
        .job_count (job_count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Instruction memory: value appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_clr) begin
            ptr        <= '0;
            imem_value <= '0;
        end else if (imem_read) begin
            imem_value <= prog[ptr];
            ptr        <= ptr + 4'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reload();
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
        tick();
    endtask

    initial begin
        int fe, ov, rd, hs, done_c, dn;
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; mem_clr = 1'b1;
        for (int i = 0; i < 16; i++) prog[i] = '0;
        #12;
        chk("rst_state", dut.state, IDLE);
        chk("rst_strobes", {imem_read, acc_clear, feed_en, out_valid, busy, done}, 0);
        chk("rst_vals", {feed_idx, drain_idx, cur_n, job_count}, 0);
        rst = 1'b0;
        tick();
        mem_clr = 1'b0;
        tick();

        // Program [2,0]: reference timeline.
        prog[0] = 4'd2; prog[1] = 4'd0;
        reload();
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            chk("t1_rd", imem_read, (c == 1 || c == 11));
            chk("t1_clr", acc_clear, (c == 3));
            chk("t1_feed", feed_en, (c == 4 || c == 5));
            chk("t1_ov", out_valid, (c == 8 || c == 9));
            chk("t1_done", done, (c == 13));
            chk("t1_busy", busy, (c <= 13));
            if (c == 3) chk("t1_curn", cur_n, 2);
            if (c == 5) chk("t1_fidx1", feed_idx, 1);
            if (c == 6) chk("t1_fidx_out", feed_idx, 0);
            if (c == 9) chk("t1_didx1", drain_idx, 1);
            if (c == 11) chk("t1_jc_mid", job_count, 1);
            tick();
        end
        chk("t1_jc", job_count, 1);

        // Program [1,0]: settle phase skipped.
        prog[0] = 4'd1; prog[1] = 4'd0;
        reload();
        fe = 0; ov = 0; done_c = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (feed_en) fe++;
            if (out_valid) ov++;
            if (done) done_c = c;
            if (c == 5) chk("t2_drain_after_feed", out_valid, 1);
            tick();
        end
        chk("t2_feed_cycles", fe, 1);
        chk("t2_ov_cycles", ov, 1);
        chk("t2_done_cycle", done_c, 9);

        // Program [3,0]: back-pressure on the second drain beat.
        prog[0] = 4'd3; prog[1] = 4'd0;
        reload();
        hs = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            out_ready = !(c >= 12 && c <= 14);
            if (out_valid && out_ready) hs++;
            if (c >= 12 && c <= 14) chk("t3_hold_idx", drain_idx, 1);
            if (c == 16) chk("t3_last_idx", drain_idx, 2);
            if (c == 17) chk("t3_next", dut.state, NEXT);
            if (c == 18) chk("t3_refetch", imem_read, 1);
            tick();
        end
        out_ready = 1'b1;
        chk("t3_handshakes", hs, 3);
        for (int c = 0; c < 4; c++) tick();

        // Eight nonzero jobs: instruction slot limit ends the run.
        for (int i = 0; i < 8; i++) prog[i] = 4'(i + 1);
        reload();
        rd = 0; dn = 0; done_c = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 300 && dn == 0; c++) begin
            if (imem_read) rd++;
            if (done) begin dn++; done_c = c; end
            tick();
        end
        chk("t4_done_seen", dn, 1);
        chk("t4_reads", rd, 8);
        chk("t4_done_cycle", done_c, 161);
        chk("t4_jc", job_count, 8);
        chk("t4_idle", busy, 0);

        // Abort in the 2nd FEED cycle of the second job (N=4); stray start ignored.
        prog[0] = 4'd1; prog[1] = 4'd4; prog[2] = 4'd0;
        reload();
        dn = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            start = (c == 10);
            abort = (c == 11);
            if (done) dn++;
            if (c == 10) chk("t5_feed0", feed_idx, 0);
            if (c == 11) begin
                chk("t5_feed1", feed_idx, 1);
                chk("t5_jc_kept", job_count, 1);
            end
            if (c == 12) begin
                chk("t5_state", dut.state, IDLE);
                chk("t5_strobes", {imem_read, acc_clear, feed_en, out_valid, busy, done}, 0);
                chk("t5_fidx", feed_idx, 0);
                chk("t5_jc", job_count, 1);
            end
            tick();
        end
        start = 1'b0; abort = 1'b0;
        chk("t5_no_done", dn, 0);
        chk("t5_still_idle", busy, 0);

        // Asynchronous reset mid-drain.
        prog[0] = 4'd2; prog[1] = 4'd0;
        reload();
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        out_ready = 1'b0;
        chk("t6_in_drain", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_strobes", {imem_read, acc_clear, feed_en, out_valid, busy, done}, 0);
        chk("t6_async_vals", {feed_idx, drain_idx, cur_n, job_count}, 0);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t6_state", dut.state, IDLE);
        chk("t6_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
